// File: rtl/seq_bcd_converter.sv
// seq_bcd_converter: bit-serial double-dabble binary-to-BCD converter with saturation and leading-zero mask
module seq_bcd_converter #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_mask
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'(~32'd1);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_next;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BW-1:0]       acc, acc_fix, acc_shift, result;
    logic [CW-1:0]       cnt;
    logic                sticky, sticky_next, last, accept, zero_run;
    logic [DIGITS-1:0]   mask_next;

    assign accept      = state == IDLE && start;
    assign last        = state == SHIFT && cnt == CW'(1);
    assign busy        = state == SHIFT;
    assign acc_shift   = {acc_fix[BW-2:0], bin_sr[BIN_WIDTH-1]};
    assign sticky_next = sticky | acc_fix[BW-1];
    assign result      = sticky_next ? ALL_NINES : acc_shift;

    // add 3 to every digit that is 5 or more, each digit on its own 4 bits
    always_comb begin
        acc_fix = acc;
        for (int i = 0; i < DIGITS; i++)
            acc_fix[4*i+:4] = (acc[4*i+:4] >= 4'd5) ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    end

    // leading-zero mask of the final result; units digit is never blanked
    always_comb begin
        mask_next = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && acc_shift[4*i+:4] == 4'd0;
            mask_next[i] = zero_run && !sticky_next;
        end
    end

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // next state: leave IDLE on start, return after the last shift
    always_comb begin
        state_next = accept ? SHIFT : last ? IDLE : state;
    end

    // shift datapath and registered results
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr     <= '0;
            acc        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
            blank_mask <= BLANK_RST;
        end else begin
            done <= last;
            if (accept) begin
                bin_sr <= bin_in;
                acc    <= '0;
                sticky <= 1'b0;
                cnt    <= CW'(BIN_WIDTH);
            end else if (state == SHIFT) begin
                bin_sr <= bin_sr << 1;
                acc    <= acc_shift;
                sticky <= sticky_next;
                cnt    <= cnt - 1'b1;
            end
            if (last) begin
                bcd_out    <= result;
                overflow   <= sticky_next;
                blank_mask <= mask_next;
            end
        end
    end
endmodule
